multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit that drives the `full_datapath` control inputs from the fetched instruction. It replaces hand-driven control stimulus. Each RV32I subset instruction steps through FETCH/DECODE/EXEC/MEM/WB, and the unit emits the datapath strobes for that step. It sits beside `full_datapath`: it reads ROM output and ALU zero, and drives `opcode`, `ALUsrc`, `RegWrite`, `MemRW`, `MemtoReg`, `PCsrc`, `pc_en`.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `instr` input 32: ROM output at the current PC.
- `zero` input 1: ALU result == 0.
- `opcode` output 4: ALU operation.
  - 0000 ZERO, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL.
- `ALUsrc` output 1: 1 = immediate, 0 = RS2.
- `RegWrite` output 1: register file write enable.
- `MemRW` output 1: 1 = RAM write.
- `MemtoReg` output 1: 1 = RAM data, 0 = ALU result.
- `PCsrc` output 1: 1 = branch/jump target, 0 = PC+4.
- `pc_en` output 1: PC register load strobe.
- `retire` output 1: one-cycle pulse per completed instruction.
- `illegal` output 1: sticky; an unsupported instruction was decoded.
- `state` output 3: current FSM state, for debug.

## Operation
- IR (32-bit) loads `instr` at the end of FETCH and is held until the next FETCH.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Transitions:
  - FETCH→DECODE always.
  - DECODE→EXEC for a legal opcode; otherwise →HALT and set `illegal`.
  - R-type (0110011) and I-ALU (0010011): EXEC→WB→FETCH.
  - LW (0000011): EXEC→MEM→WB→FETCH.
  - SW (0100011): EXEC→MEM→FETCH.
  - BEQ (1100011) and JAL (1101111): EXEC→FETCH.
  - HALT is absorbing until `reset`.
- ALU op from funct3/funct7[5]:
  - R-type: add/sub/and/or/xor/sll/srl.
  - I-ALU: addi/andi/ori/xori/slli/srli.
  - LW/SW: ADD. BEQ: SUB. JAL: ZERO.
  - Any other funct3/funct7 combination is illegal.
- Outputs are decoded from state + IR:
  - `opcode` and `ALUsrc` hold from EXEC through the last state of the instruction. They are 0 in FETCH, DECODE and HALT.
  - `ALUsrc`=1 for I-ALU, LW and SW; 0 otherwise.
  - `MemRW`=1 only in MEM of SW.
  - `MemtoReg`=1 in MEM and WB of LW.
  - `RegWrite`=1 only in WB.
  - `PCsrc` in EXEC: BEQ → `zero`; JAL → 1. It is 0 in all other states.
  - `pc_en`=`retire`=1 in the final state of each instruction (WB, SW's MEM, or branch/jump EXEC).
- JAL does not write rd (rd=x0 only); a nonzero rd is illegal.

## Timing
- Reset values:
  - Sampled `reset` forces state=FETCH, IR=0, `illegal`=0.
  - All outputs are 0 in the cycle following the reset edge.
  - Reset mid-instruction aborts it with no `RegWrite`, `MemRW` or `pc_en` pulse.
- Latency in cycles: R/I = 4, LW = 5, SW = 4, BEQ/JAL = 3.
- `zero` is used combinationally only in EXEC of BEQ. The datapath samples `PCsrc`/`pc_en` at the closing edge of EXEC.
- `instr` is sampled only in FETCH. Changes in other states have no effect.
- Strobes (`RegWrite`, `MemRW`, `pc_en`) are exactly one cycle per instruction; never two in a row.

## Configuration
- `CTRL_BRANCH_EN` defined: BEQ and JAL are decoded as above.
- `CTRL_BRANCH_EN` undefined:
  - 1100011 and 1101111 are illegal (→HALT).
  - `PCsrc` is tied to 0.

## Structure
- `ctrl_pkg` holds:
  - the state encoding;
  - the 7-bit major opcode constants;
  - the 4-bit ALU op constants (shared with the ALU).
- One sub-module, `alu_op_decoder`: combinational; inputs IR major opcode, funct3 and funct7[5]; outputs ALU op plus an illegal flag.
- The FSM and IR live in `multicycle_control`.

## Test plan
- Reset 2 cycles, `instr`=0x00D00713 (addi x14,x0,13) → states 0,1,2,4.
  - EXEC: `opcode`=0001, `ALUsrc`=1.
  - WB: `RegWrite`=1, `MemtoReg`=0, `pc_en`=`retire`=1.
- `instr`=0x00E02023 (sw x14,0(x0)) → MEM: `MemRW`=1, `RegWrite`=0, `pc_en`=1; 4 cycles total.
- `instr`=0x00002783 (lw x15,0(x0)) → MEM and WB: `MemtoReg`=1; WB: `RegWrite`=1; 5 cycles.
- `instr`=0x402081B3 (sub x3,x1,x2) → EXEC: `opcode`=0010, `ALUsrc`=0.
- `instr`=0x00000463 (beq) with `zero`=1 → EXEC: `PCsrc`=1, `pc_en`=1; repeat with `zero`=0 → `PCsrc`=0. With `CTRL_BRANCH_EN` off → HALT, `illegal`=1.
- `instr`=0xFFFFFFFF → HALT, `illegal`=1, no strobes for 10 cycles; then `reset` → FETCH, `illegal`=0. Also assert `reset` during MEM of SW → no `MemRW` pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, RV32I major
// opcodes and the 4-bit ALU operation codes understood by the datapath ALU.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [3:0] ALU_ZERO = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU-op decode from major opcode, funct3 and funct7[5].
// BEQ/JAL are accepted only when CTRL_BRANCH_EN is defined.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] major,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_op,
    output logic       illegal
);

    // Map each supported instruction to its ALU operation; anything else is illegal.
    always_comb begin
        alu_op  = ALU_ZERO;
        illegal = 1'b0;
        case (major)
            OP_RTYPE: begin
                case ({funct7_b5, funct3})
                    4'b0_000: alu_op = ALU_ADD;
                    4'b1_000: alu_op = ALU_SUB;
                    4'b0_111: alu_op = ALU_AND;
                    4'b0_110: alu_op = ALU_OR;
                    4'b0_100: alu_op = ALU_XOR;
                    4'b0_001: alu_op = ALU_SLL;
                    4'b0_101: alu_op = ALU_SRL;
                    default:  illegal = 1'b1;
                endcase
            end
            OP_IALU: begin
                // funct7[5] is immediate data except for shifts, where it selects srai/slli-variants
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b100:  alu_op = ALU_XOR;
                    3'b001: begin
                        if (!funct7_b5) alu_op = ALU_SLL;
                        else            illegal = 1'b1;
                    end
                    3'b101: begin
                        if (!funct7_b5) alu_op = ALU_SRL;
                        else            illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW, OP_SW: begin
                if (funct3 == 3'b010) alu_op = ALU_ADD;
                else                  illegal = 1'b1;
            end
`ifdef CTRL_BRANCH_EN
            OP_BEQ: begin
                if (funct3 == 3'b000) alu_op = ALU_SUB;
                else                  illegal = 1'b1;
            end
            OP_JAL: alu_op = ALU_ZERO;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving full_datapath strobes.
// Define CTRL_BRANCH_EN to support BEQ/JAL; otherwise they halt as illegal and PCsrc is 0.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  opcode,
    output logic        ALUsrc,
    output logic        RegWrite,
    output logic        MemRW,
    output logic        MemtoReg,
    output logic        PCsrc,
    output logic        pc_en,
    output logic        retire,
    output logic        illegal,
    output logic [2:0]  state
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [6:0]  major_s;
    logic [3:0]  dec_op_s;
    logic        dec_illegal_s;
    logic        jal_rd_bad_s;
    logic        alusrc_s;
    logic        regwrite_s;
    logic        memrw_s;
    logic        finish_s;
    logic        unused_s;

    assign major_s      = ir_q[6:0];
    assign jal_rd_bad_s = (major_s == OP_JAL) && (ir_q[11:7] != 5'd0);
    assign alusrc_s     = (major_s == OP_IALU) || (major_s == OP_LW) || (major_s == OP_SW);
    assign unused_s     = ^{ir_q, zero};

    alu_op_decoder u_alu_op_decoder (
        .major     (major_s),
        .funct3    (ir_q[14:12]),
        .funct7_b5 (ir_q[30]),
        .alu_op    (dec_op_s),
        .illegal   (dec_illegal_s)
    );

    // State, instruction register and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and per-step datapath controls.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        opcode     = ALU_ZERO;
        ALUsrc     = 1'b0;
        MemtoReg   = 1'b0;
        PCsrc      = 1'b0;
        regwrite_s = 1'b0;
        memrw_s    = 1'b0;
        finish_s   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal_s || jal_rd_bad_s) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                opcode = dec_op_s;
                ALUsrc = alusrc_s;
                case (major_s)
                    OP_RTYPE, OP_IALU: state_d = ST_WB;
                    OP_LW, OP_SW:      state_d = ST_MEM;
`ifdef CTRL_BRANCH_EN
                    OP_BEQ: begin
                        PCsrc    = zero;
                        finish_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    OP_JAL: begin
                        PCsrc    = 1'b1;
                        finish_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
`endif
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                opcode = dec_op_s;
                ALUsrc = alusrc_s;
                if (major_s == OP_SW) begin
                    memrw_s  = 1'b1;
                    finish_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    MemtoReg = 1'b1;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                opcode     = dec_op_s;
                ALUsrc     = alusrc_s;
                MemtoReg   = (major_s == OP_LW);
                regwrite_s = 1'b1;
                finish_s   = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // A reset arriving in the final step suppresses that step's write/PC strobes.
    assign RegWrite = regwrite_s & ~reset;
    assign MemRW    = memrw_s & ~reset;
    assign pc_en    = finish_s & ~reset;
    assign retire   = finish_s & ~reset;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control plus hand sequences for branch,
// illegal-halt and reset corner cases (branch rows follow CTRL_BRANCH_EN).
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] op;
        logic       src;
        logic       rw;
        logic       mrw;
        logic       m2r;
        logic       pcs;
        logic       pce;
        logic       ret;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] I_ADDI = 32'h00D00713;
    localparam logic [31:0] I_SW   = 32'h00E02023;
    localparam logic [31:0] I_LW   = 32'h00002783;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_SRLI = 32'h0012D293;
    localparam logic [31:0] I_SRAI = 32'h4012D293;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_JAL0 = 32'h0000006F;
    localparam logic [31:0] I_JAL1 = 32'h000000EF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic [3:0]  opcode;
    logic        ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_en, retire, illegal;
    logic [2:0]  state;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    vec_t vecs[$];

    multicycle_control dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .zero     (zero),
        .opcode   (opcode),
        .ALUsrc   (ALUsrc),
        .RegWrite (RegWrite),
        .MemRW    (MemRW),
        .MemtoReg (MemtoReg),
        .PCsrc    (PCsrc),
        .pc_en    (pc_en),
        .retire   (retire),
        .illegal  (illegal),
        .state    (state)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input int st, input int op, input int src, input int rw,
                                input int mrw, input int m2r, input int pcs, input int pce,
                                input int ill);
        outs_t r;
        r.st  = st[2:0];
        r.op  = op[3:0];
        r.src = src[0];
        r.rw  = rw[0];
        r.mrw = mrw[0];
        r.m2r = m2r[0];
        r.pcs = pcs[0];
        r.pce = pce[0];
        r.ret = pce[0];
        r.ill = ill[0];
        return r;
    endfunction

    function automatic void add(input int r, input logic [31:0] ins, input int z, input outs_t e);
        vec_t v;
        v.rst   = r[0];
        v.instr = ins;
        v.zero  = z[0];
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic [31:0] ins, input logic z,
                         input outs_t e, input string nm);
        outs_t act;
        @(negedge clk);
        reset = r;
        instr = ins;
        zero  = z;
        #1;
        act = {state, opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_en, retire, illegal};
        total_cnt = total_cnt + 1;
        if (act === e) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: actual st=%0d op=%b src/rw/mrw/m2r/pcs/pce/ret/ill=%b, required st=%0d op=%b src/rw/mrw/m2r/pcs/pce/ret/ill=%b",
                     nm, act.st, act.op, act[7:0], e.st, e.op, e[7:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // addi x14,x0,13
        add(0, I_ADDI, 0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(4,1,1,1,0,0,0,1,0));
        // sw x14,0(x0)
        add(0, I_SW,   0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(3,1,1,0,1,0,0,1,0));
        // lw x15,0(x0)
        add(0, I_LW,   0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(3,1,1,0,0,1,0,0,0));
        add(0, I_BAD,  0, o(4,1,1,1,0,1,0,1,0));
        // sub x3,x1,x2 with zero high: PCsrc must stay 0
        add(0, I_SUB,  0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  1, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  1, o(2,2,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(4,2,0,1,0,0,0,1,0));
        // and x3,x1,x2
        add(0, I_AND,  0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,3,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(4,3,0,1,0,0,0,1,0));
        // srli x5,x5,1
        add(0, I_SRLI, 0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,7,1,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(4,7,1,1,0,0,0,1,0));
        // lw aborted by reset in EXEC
        add(0, I_LW,   0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(1, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        // sw aborted by reset in MEM: no MemRW / pc_en
        add(0, I_SW,   0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        add(1, I_BAD,  0, o(3,1,1,0,0,0,0,0,0));
        // clean addi after aborts
        add(0, I_ADDI, 0, o(0,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(2,1,1,0,0,0,0,0,0));
        add(0, I_BAD,  0, o(4,1,1,1,0,0,0,1,0));

        reset = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].instr, vecs[i].zero, vecs[i].exp, $sformatf("vec%0d", i));
        end

`ifdef CTRL_BRANCH_EN
        apply(0, I_BEQ,  0, o(0,0,0,0,0,0,0,0,0), "beq_t fetch");
        apply(0, I_BAD,  1, o(1,0,0,0,0,0,0,0,0), "beq_t decode");
        apply(0, I_BAD,  1, o(2,2,0,0,0,0,1,1,0), "beq_t exec");
        apply(0, I_BEQ,  0, o(0,0,0,0,0,0,0,0,0), "beq_n fetch");
        apply(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0), "beq_n decode");
        apply(0, I_BAD,  0, o(2,2,0,0,0,0,0,1,0), "beq_n exec");
        apply(0, I_JAL0, 0, o(0,0,0,0,0,0,0,0,0), "jal fetch");
        apply(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0), "jal decode");
        apply(0, I_BAD,  0, o(2,0,0,0,0,0,1,1,0), "jal exec");
`else
        apply(0, I_BEQ,  0, o(0,0,0,0,0,0,0,0,0), "beq_off fetch");
        apply(0, I_BAD,  1, o(1,0,0,0,0,0,0,0,0), "beq_off decode");
        apply(1, I_BAD,  1, o(5,0,0,0,0,0,0,0,1), "beq_off halt");
`endif
        // jal with rd != x0 is illegal in both builds
        apply(0, I_JAL1, 0, o(0,0,0,0,0,0,0,0,0), "jal_rd fetch");
        apply(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0), "jal_rd decode");
        apply(1, I_BAD,  0, o(5,0,0,0,0,0,0,0,1), "jal_rd halt");

        // all-ones word: halt absorbs regardless of instr/zero until reset
        apply(0, I_BAD,  0, o(0,0,0,0,0,0,0,0,0), "bad fetch");
        apply(0, I_ADDI, 0, o(1,0,0,0,0,0,0,0,0), "bad decode");
        for (int k = 0; k < 10; k++) begin
            apply(0, I_ADDI, k[0], o(5,0,0,0,0,0,0,0,1), $sformatf("bad halt%0d", k));
        end
        apply(1, I_ADDI, 0, o(5,0,0,0,0,0,0,0,1), "bad halt reset");
        apply(0, I_SRAI, 0, o(0,0,0,0,0,0,0,0,0), "post reset fetch");

        // srai is not in the subset
        apply(0, I_BAD,  0, o(1,0,0,0,0,0,0,0,0), "srai decode");
        apply(0, I_BAD,  0, o(5,0,0,0,0,0,0,0,1), "srai halt");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
